// File: rtl/jtdd_dwnld_pkg.sv
// Shared types and default memory-map constants for the download router.
package jtdd_dwnld_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PROM = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RG_SDRAM = 2'd0,
    RG_PROM  = 2'd1,
    RG_DROP  = 2'd2
  } region_e;

  localparam int          DEF_AW         = 22;
  localparam logic [21:0] DEF_BA1_START  = 22'h030000;
  localparam logic [21:0] DEF_BA2_START  = 22'h060000;
  localparam logic [21:0] DEF_BA3_START  = 22'h0A0000;
  localparam logic [21:0] DEF_PROM_START = 22'h124000;

endpackage

// File: rtl/jtdd_dwnld_fifo.sv
// Small synchronous FIFO; flush empties it but still stores a same-cycle push.
module jtdd_dwnld_fifo #(
  parameter int W  = 30,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         wr_en;
  logic [AW-1:0] wr_idx;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  assign wr_en  = push_i && (flush_i || !full_o);
  assign wr_idx = flush_i ? '0 : wr_q[AW-1:0];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      rd_d = '0;
      wr_d = push_i ? (AW+1)'(1) : '0;
    end else begin
      if (wr_en) wr_d = wr_q + 1'b1;
      if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= din_i;
  end

endmodule

// File: rtl/jtdd_dwnld_router.sv
// Routes ioctl bytes to SDRAM banks (prog_we/prog_ack handshake) or PROM strobes.
// Handshake: prog_we_o is held with stable outputs until a cycle where prog_ack_i=1.
module jtdd_dwnld_router
  import jtdd_dwnld_pkg::*;
#(
  parameter int            AW         = DEF_AW,
  parameter logic [AW-1:0] BA1_START  = AW'(DEF_BA1_START),
  parameter logic [AW-1:0] BA2_START  = AW'(DEF_BA2_START),
  parameter logic [AW-1:0] BA3_START  = AW'(DEF_BA3_START),
  parameter logic [AW-1:0] PROM_START = AW'(DEF_PROM_START),
  parameter int            PROM_CNT   = 2,
  parameter int            PROM_AW    = 8,
  parameter logic [3:0]    SWAB       = 4'b0000,
  parameter int            FIFO_AW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading_i,
  input  logic [AW-1:0]       ioctl_addr_i,
  input  logic [7:0]          ioctl_data_i,
  input  logic                ioctl_wr_i,
  output logic [AW-2:0]       prog_addr_o,
  output logic [1:0]          prog_ba_o,
  output logic [15:0]         prog_data_o,
  output logic [1:0]          prog_mask_o,
  output logic                prog_we_o,
  input  logic                prog_ack_i,
  output logic [PROM_CNT-1:0] prom_we_o,
  output logic [PROM_AW-1:0]  prom_addr_o,
  output logic [7:0]          prom_data_o,
  output logic                ovf_o,
  output logic                busy_o,
  output state_e              dbg_state_o
);
  localparam int FW = AW + 8;
  localparam int IW = AW - PROM_AW;

  state_e state_q, state_d;
  logic dl_q, rise, ovf_q, ovf_d;
  logic [FW-1:0] head;
  logic fifo_full, fifo_empty, pop;

  logic [AW-1:0] head_a, dec_off, dec_p;
  logic [7:0]    head_d;
  logic [1:0]    dec_ba;
  logic [IW-1:0] dec_idx;
  region_e       dec_rg;

  logic [AW-2:0]       prog_addr_q, prog_addr_d;
  logic [1:0]          prog_ba_q, prog_ba_d, prog_mask_q, prog_mask_d;
  logic [15:0]         prog_data_q, prog_data_d;
  logic [PROM_CNT-1:0] prom_sel_q, prom_sel_d;
  logic [PROM_AW-1:0]  prom_addr_q, prom_addr_d;
  logic [7:0]          prom_data_q, prom_data_d;

  assign rise = downloading_i & ~dl_q;

  jtdd_dwnld_fifo #(.W(FW), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (rise),
    .push_i  (ioctl_wr_i),
    .din_i   ({ioctl_addr_i, ioctl_data_i}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_a  = head[FW-1:8];
  assign head_d  = head[7:0];
  assign dec_p   = head_a - PROM_START;
  assign dec_idx = dec_p[AW-1:PROM_AW];

  always_comb begin
    dec_ba  = 2'd0;
    dec_off = head_a;
    dec_rg  = RG_SDRAM;
    if (head_a < BA1_START) begin
      dec_ba = 2'd0;
    end else if (head_a < BA2_START) begin
      dec_ba  = 2'd1;
      dec_off = head_a - BA1_START;
    end else if (head_a < BA3_START) begin
      dec_ba  = 2'd2;
      dec_off = head_a - BA2_START;
    end else if (head_a < PROM_START) begin
      dec_ba  = 2'd3;
      dec_off = head_a - BA3_START;
    end else begin
      // Index keeps all upper bits so far-out addresses never alias onto a PROM.
      dec_rg = (dec_idx < IW'(PROM_CNT)) ? RG_PROM : RG_DROP;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_ba_d   = prog_ba_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prom_sel_d  = prom_sel_q;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !rise) begin
          pop = 1'b1;
          if (dec_rg == RG_SDRAM) begin
            state_d     = ST_REQ;
            prog_addr_d = dec_off[AW-1:1];
            prog_ba_d   = dec_ba;
            prog_data_d = {head_d, head_d};
            prog_mask_d = (dec_off[0] ^ SWAB[dec_ba]) ? 2'b10 : 2'b01;
          end else if (dec_rg == RG_PROM) begin
            state_d     = ST_PROM;
            prom_sel_d  = PROM_CNT'(1) << dec_idx;
            prom_addr_d = dec_p[PROM_AW-1:0];
            prom_data_d = head_d;
          end
        end
      end
      ST_REQ:  if (prog_ack_i) state_d = ST_IDLE;
      ST_PROM: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ovf_d = rise ? 1'b0 : (ovf_q | (ioctl_wr_i & fifo_full));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dl_q        <= 1'b0;
      ovf_q       <= 1'b0;
      prog_addr_q <= '0;
      prog_ba_q   <= '0;
      prog_data_q <= '0;
      prog_mask_q <= '0;
      prom_sel_q  <= '0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
    end else begin
      state_q     <= state_d;
      dl_q        <= downloading_i;
      ovf_q       <= ovf_d;
      prog_addr_q <= prog_addr_d;
      prog_ba_q   <= prog_ba_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prom_sel_q  <= prom_sel_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
    end
  end

  assign prog_addr_o = prog_addr_q;
  assign prog_ba_o   = prog_ba_q;
  assign prog_data_o = prog_data_q;
  assign prog_mask_o = prog_mask_q;
  assign prog_we_o   = (state_q == ST_REQ);
  assign prom_we_o   = (state_q == ST_PROM) ? prom_sel_q : '0;
  assign prom_addr_o = prom_addr_q;
  assign prom_data_o = prom_data_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = downloading_i | ~fifo_empty | (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jtdd_dwnld_router.sv
// Scoreboard bench for jtdd_dwnld_router: reference model fills exp_q, monitor pops on each write.
module tb_jtdd_dwnld_router;
  import jtdd_dwnld_pkg::*;

  localparam int EW = 42;
  localparam logic [3:0] SWAB_TB = 4'b0010;

  logic clk = 1'b0;
  logic rst;
  logic downloading, ioctl_wr, prog_ack;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [20:0] prog_addr;
  logic [1:0]  prog_ba, prog_mask, prom_we;
  logic [15:0] prog_data;
  logic        prog_we, ovf, busy;
  logic [7:0]  prom_addr, prom_data;
  state_e      dbg_state;

  jtdd_dwnld_router #(.SWAB(SWAB_TB)) dut (
    .clk           (clk),
    .rst           (rst),
    .downloading_i (downloading),
    .ioctl_addr_i  (ioctl_addr),
    .ioctl_data_i  (ioctl_data),
    .ioctl_wr_i    (ioctl_wr),
    .prog_addr_o   (prog_addr),
    .prog_ba_o     (prog_ba),
    .prog_data_o   (prog_data),
    .prog_mask_o   (prog_mask),
    .prog_we_o     (prog_we),
    .prog_ack_i    (prog_ack),
    .prom_we_o     (prom_we),
    .prom_addr_o   (prom_addr),
    .prom_data_o   (prom_data),
    .ovf_o         (ovf),
    .busy_o        (busy),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  bit ack_hold = 1'b0, ack_rand = 1'b0, ack_noise = 1'b0;
  int ack_fixed = 0, hi_cnt = 0, cur_delay = 0;

  function automatic logic [EW-1:0] pack_sdram(input logic [1:0] ba, input logic [20:0] a,
                                               input logic [1:0] m, input logic [15:0] d);
    return {1'b0, ba, a, m, d};
  endfunction

  function automatic logic [EW-1:0] pack_prom(input logic [1:0] we, input logic [7:0] a,
                                              input logic [7:0] d);
    return {1'b1, 2'b00, 11'd0, we, a, 2'b00, 8'h00, d};
  endfunction

  // Reference: address map applied with plain integer arithmetic.
  function automatic logic [EW-1:0] model(input logic [21:0] a, input logic [7:0] d,
                                          output bit valid);
    int unsigned ai, off, p, idx;
    int bank;
    logic lane;
    ai = a;
    valid = 1'b1;
    bank = 0;
    off = ai;
    if (ai < 'h30000) begin
      bank = 0; off = ai;
    end else if (ai < 'h60000) begin
      bank = 1; off = ai - 'h30000;
    end else if (ai < 'hA0000) begin
      bank = 2; off = ai - 'h60000;
    end else if (ai < 'h124000) begin
      bank = 3; off = ai - 'hA0000;
    end else begin
      p = ai - 'h124000;
      idx = p / 256;
      if (idx < 2) return pack_prom(2'(1 << idx), 8'(p % 256), d);
      valid = 1'b0;
      return '0;
    end
    lane = 1'((off % 2) ^ SWAB_TB[bank]);
    return pack_sdram(2'(bank), 21'(off / 2), lane ? 2'b10 : 2'b01, {d, d});
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_obs(input logic [EW-1:0] got);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write: got=%h expected=none at %0t", got, $time);
    end else begin
      e = exp_q.pop_front();
      chk("write", 64'(got), 64'(e));
    end
    done_cnt++;
  endtask

  // monitor + SDRAM ack responder
  always @(negedge clk) begin
    logic ack_n;
    ack_n = 1'b0;
    if (rst) begin
      hi_cnt = 0;
    end else begin
      if (prog_we) begin
        if (!ack_hold) begin
          if (hi_cnt >= cur_delay) ack_n = 1'b1;
          else hi_cnt++;
        end
      end else begin
        hi_cnt = 0;
        if (ack_noise) ack_n = 1'($urandom_range(0, 1));
      end
      if (prog_we && ack_n) begin
        compare_obs(pack_sdram(prog_ba, prog_addr, prog_mask, prog_data));
        hi_cnt = 0;
        cur_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_fixed;
      end
      if (prom_we != 2'b00) compare_obs(pack_prom(prom_we, prom_addr, prom_data));
    end
    prog_ack = ack_n;
  end

  // driver tasks
  task automatic set_ack(input bit hold, input int fixed, input bit rnd, input bit noise);
    ack_hold = hold;
    ack_fixed = fixed;
    cur_delay = fixed;
    ack_rand = rnd;
    ack_noise = noise;
  endtask

  task automatic expect_entry(input logic [21:0] a, input logic [7:0] d);
    bit v;
    logic [EW-1:0] e;
    e = model(a, d, v);
    if (v) exp_q.push_back(e);
  endtask

  task automatic do_write(input logic [21:0] a, input logic [7:0] d, input bit expect_it);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1'b1;
    if (expect_it) expect_entry(a, d);
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got=%0d pending expected=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 22'($urandom_range(0, 'h2FFFF));
      1: return 22'($urandom_range('h30000, 'h5FFFF));
      2: return 22'($urandom_range('h60000, 'h9FFFF));
      3: return 22'($urandom_range('hA0000, 'h123FFF));
      default: return 22'($urandom_range('h124000, 'h1241FF));
    endcase
  endfunction

  logic [21:0] bnd_tab [11] = '{22'h2FFFF, 22'h30000, 22'h5FFFF, 22'h60000, 22'h9FFFF,
                                22'hA0000, 22'h123FFF, 22'h124000, 22'h1240FF,
                                22'h124100, 22'h1241FF};

  initial begin
    int target, n;
    bit busy_bad;
    rst = 1'b1;
    downloading = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_data = '0;
    prog_ack = 1'b0;
    set_ack(1'b0, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_prog_we", 64'(prog_we), 64'd0);
    chk("rst_prom_we", 64'(prom_we), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_prog_fields", 64'({prog_addr, prog_ba, prog_mask, prog_data}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // Two bytes of one word, ack one cycle late; first byte also checks latency.
    @(negedge clk);
    downloading = 1'b1;
    repeat (2) @(negedge clk);
    ioctl_addr = 22'h0;
    ioctl_data = 8'hAA;
    ioctl_wr = 1'b1;
    expect_entry(22'h0, 8'hAA);
    @(posedge clk); #1;
    chk("lat_n1_prog_we", 64'(prog_we), 64'd0);
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(posedge clk); #1;
    chk("lat_n2_prog_we", 64'(prog_we), 64'd1);
    do_write(22'h1, 8'h55, 1'b1);
    wait_drain("t1_drain");

    // Swapped bank 1.
    do_write(22'h30002, 8'h12, 1'b1);
    wait_drain("t2_drain");

    // Overflow with ack held low.
    set_ack(1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ioctl_addr = 22'(i * 3);
      ioctl_data = 8'(8'h60 + i);
      ioctl_wr = 1'b1;
      if (i < 5) expect_entry(22'(i * 3), 8'(8'h60 + i));
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("t3_ovf_set", 64'(ovf), 64'd1);
    chk("t3_busy", 64'(busy), 64'd1);
    set_ack(1'b0, 0, 1'b0, 1'b0);
    wait_drain("t3_drain");
    chk("t3_ovf_sticky", 64'(ovf), 64'd1);
    @(negedge clk);
    downloading = 1'b0;
    @(negedge clk);
    downloading = 1'b1;
    @(posedge clk); #1;
    chk("t3_ovf_clear", 64'(ovf), 64'd0);

    // Boundary addresses of every region.
    for (int i = 0; i < 11; i++) do_write(bnd_tab[i], 8'($urandom_range(0, 255)), 1'b1);
    wait_drain("bnd_drain");

    // Random traffic with random ack latency and stray acks.
    set_ack(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      n = 0;
      while (exp_q.size() >= 3 && n < 200) begin
        @(negedge clk);
        n++;
      end
      do_write(rand_addr(), 8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("rand_drain");

    // PROM strobe and discarded PROM-region entries.
    set_ack(1'b0, 0, 1'b0, 1'b0);
    do_write(22'h124105, 8'h3C, 1'b1);
    wait_drain("t4_drain");
    do_write(22'h124205, 8'h77, 1'b1);
    do_write(22'h3FFFFF, 8'h88, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_discard_prog_we", 64'(prog_we), 64'd0);
    chk("t4_discard_prom_we", 64'(prom_we), 64'd0);
    chk("t4_discard_queue", 64'(exp_q.size()), 64'd0);

    // busy holds after downloading drops until the last ack.
    set_ack(1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_write(22'(22'h40000 + i), 8'(8'hC0 + i), 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    downloading = 1'b0;
    @(posedge clk); #1;
    chk("t6_busy_after_drop", 64'(busy), 64'd1);
    target = done_cnt + 3;
    set_ack(1'b0, 1, 1'b0, 1'b0);
    busy_bad = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done_cnt >= target) break;
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
    chk("t6_busy_held", 64'(busy_bad), 64'd0);
    chk("t6_busy_fall", 64'(busy), 64'd0);
    wait_drain("t6_drain");

    // Reset in the middle of a held request with entries queued.
    set_ack(1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ioctl_addr = 22'(22'h70000 + i);
      ioctl_data = 8'(8'h90 + i);
      ioctl_wr = 1'b1;
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_pre_prog_we", 64'(prog_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_prog_we", 64'(prog_we), 64'd0);
    chk("t5_rst_prom_we", 64'(prom_we), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_fields", 64'({prog_addr, prog_ba, prog_mask, prog_data, ovf}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_ack(1'b0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("t5_busy_after", 64'(busy), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_stale_we", 64'(prog_we), 64'd0);
    chk("t5_state_idle", 64'(dbg_state), 64'(ST_IDLE));

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
